fetch_buffer: RTL and testbench



---
 rtl/fetch_buffer_if.sv | 38 +++
 rtl/fetch_buffer.sv | 139 +++++++++++++
 tb/tb_fetch_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bus: enqueue channel from fetch and dequeue channel to decode.
// Signal suffixes (_i/_o) are named from the buffer's point of view.
// slave  : the fetch buffer itself.
// master : the surrounding fetch/decode logic (or a testbench).
interface fetch_buffer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  // enqueue side (fetch -> buffer)
  logic               enq_valid_i;
  logic               enq_ready_o;
  logic [PC_W-1:0]    enq_pc_i;
  logic [INSTR_W-1:0] enq_instr_i;
  logic               enq_pred_taken_i;
  logic [PC_W-1:0]    enq_pred_target_i;

  // dequeue side (buffer -> decode)
  logic               deq_valid_o;
  logic               deq_ready_i;
  logic [PC_W-1:0]    deq_pc_o;
  logic [INSTR_W-1:0] deq_instr_o;
  logic               deq_pred_taken_o;
  logic [PC_W-1:0]    deq_pred_target_o;

  modport slave (
    input  enq_valid_i, enq_pc_i, enq_instr_i, enq_pred_taken_i, enq_pred_target_i,
    output enq_ready_o,
    output deq_valid_o, deq_pc_o, deq_instr_o, deq_pred_taken_o, deq_pred_target_o,
    input  deq_ready_i
  );

  modport master (
    output enq_valid_i, enq_pc_i, enq_instr_i, enq_pred_taken_i, enq_pred_target_i,
    input  enq_ready_o,
    input  deq_valid_o, deq_pc_o, deq_instr_o, deq_pred_taken_o, deq_pred_target_o,
    output deq_ready_i
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FIFO between fetch and decode/rename.
// Holds instruction word, PC and prediction metadata; presents entries in
// program order with first-word-fall-through; flush empties it in one cycle.
// Pointers carry an extra wrap bit so full/empty need no separate counter.
// Optional macro FETCH_BUF_BYPASS_EN: when the buffer is empty an incoming
// entry is presented on deq_* in the same cycle and, if taken, never stored.
// DEPTH must equal 2**PTR_W.
module fetch_buffer #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  fetch_buffer_if.slave    bus,
  output logic [PTR_W:0]   count_o
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pred_taken;
    logic [PC_W-1:0]    pred_target;
  } entry_t;

  logic [PTR_W:0]   head_q, head_d;
  logic [PTR_W:0]   tail_q, tail_d;
  logic [PTR_W-1:0] head_idx, tail_idx;

  logic   empty, full;
  logic   enq_ready, deq_valid;
  logic   enq_fire, deq_fire;
  logic   bypass_take;
  entry_t enq_entry, head_entry, deq_entry;
  entry_t entry_rd [DEPTH];

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  // Occupancy status from the wrap-bit pointer pair.
  always_comb begin
    empty = (head_q == tail_q);
    full  = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
  end

  // Pack the incoming fields into one storage word.
  always_comb begin
    enq_entry.pc          = bus.enq_pc_i;
    enq_entry.instr       = bus.enq_instr_i;
    enq_entry.pred_taken  = bus.enq_pred_taken_i;
    enq_entry.pred_target = bus.enq_pred_target_i;
  end

  assign head_entry = entry_rd[head_idx];

  // Handshake and output selection; flush masks both sides for the cycle.
  always_comb begin
    enq_ready   = !full && !flush_i;
    deq_valid   = !empty && !flush_i;
    deq_entry   = head_entry;
    bypass_take = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    // Empty buffer: hand the fetch entry straight to decode.
    if (empty && bus.enq_valid_i && !flush_i) begin
      deq_valid   = 1'b1;
      deq_entry   = enq_entry;
      bypass_take = bus.deq_ready_i;
    end
`endif
    // A bypassed entry that decode accepts is never written.
    enq_fire = bus.enq_valid_i && enq_ready && !bypass_take;
    // Only stored entries move the head pointer.
    deq_fire = !empty && !flush_i && bus.deq_ready_i;
  end

  // Next pointer values; flush returns both pointers to zero.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage: one register per entry, written only when the tail points at it.
  // Entries are cleared on reset so deq_* read as zero straight out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_t entry_q, entry_d;
      logic   wr_en;

      assign wr_en = enq_fire && (tail_idx == PTR_W'(gi));

      // Hold unless this slot is the enqueue target.
      always_comb begin
        entry_d = entry_q;
        if (wr_en) entry_d = enq_entry;
      end

      // Entry register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= '0;
        else        entry_q <= entry_d;
      end

      assign entry_rd[gi] = entry_q;
    end
  endgenerate

  // Drive the bus and the occupancy count.
  always_comb begin
    bus.enq_ready_o       = enq_ready;
    bus.deq_valid_o       = deq_valid;
    bus.deq_pc_o          = deq_entry.pc;
    bus.deq_instr_o       = deq_entry.instr;
    bus.deq_pred_taken_o  = deq_entry.pred_taken;
    bus.deq_pred_target_o = deq_entry.pred_target;
    count_o               = tail_q - head_q;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer. Each scenario task drives stimulus and
// checks outputs inline. Inputs change 1 time unit after the rising edge and
// outputs are checked in the same window, well away from the next edge.
// Entry payload is derived from the PC so every field can be checked.
module tb_fetch_buffer;
  localparam int PTR_W = 3;

  logic           clk;
  logic           rst_n;
  logic           flush_i;
  logic [PTR_W:0] count_o;
  int             total;
  int             bad;

  fetch_buffer_if #(.PC_W(8), .INSTR_W(32)) bus ();

  fetch_buffer #(.DEPTH(8), .PTR_W(PTR_W), .PC_W(8), .INSTR_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus),
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr(input logic [7:0] pc);
    return {24'hC0DE5A, pc};
  endfunction

  function automatic logic [7:0] exp_target(input logic [7:0] pc);
    return pc ^ 8'hFF;
  endfunction

  function automatic logic exp_taken(input logic [7:0] pc);
    return pc[0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [7:0] pc);
    bus.enq_valid_i       = v;
    bus.enq_pc_i          = pc;
    bus.enq_instr_i       = exp_instr(pc);
    bus.enq_pred_taken_i  = exp_taken(pc);
    bus.enq_pred_target_i = exp_target(pc);
  endtask

  // Enqueue n consecutive PCs with decode stalled.
  task automatic load(input logic [7:0] first_pc, input int n);
    bus.deq_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_enq(1'b1, first_pc + 8'(i));
      step();
      $display("enq pc=%02h count=%0d", first_pc + 8'(i), count_o);
    end
    drive_enq(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total += 5;
    if (count_o !== 4'd0)          begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
    if (bus.deq_valid_o !== 1'b0)  begin bad++; $display("FAIL reset_deq_valid got=%b want=0", bus.deq_valid_o); end
    if (bus.enq_ready_o !== 1'b1)  begin bad++; $display("FAIL reset_enq_ready got=%b want=1", bus.enq_ready_o); end
    if (bus.deq_pc_o !== 8'h00)    begin bad++; $display("FAIL reset_deq_pc got=%h want=00", bus.deq_pc_o); end
    if (bus.deq_instr_o !== 32'h0) begin bad++; $display("FAIL reset_deq_instr got=%h want=0", bus.deq_instr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    load(8'h00, 8);
    total += 3;
    if (count_o !== 4'd8)          begin bad++; $display("FAIL fill_count got=%0d want=8", count_o); end
    if (bus.enq_ready_o !== 1'b0)  begin bad++; $display("FAIL fill_enq_ready got=%b want=0", bus.enq_ready_o); end
    if (bus.deq_pc_o !== 8'h00)    begin bad++; $display("FAIL fill_head_pc got=%h want=00", bus.deq_pc_o); end
    // A 9th entry held while full must not be taken.
    drive_enq(1'b1, 8'h08);
    step();
    total += 2;
    if (count_o !== 4'd8)          begin bad++; $display("FAIL fill_ninth_count got=%0d want=8", count_o); end
    if (bus.deq_pc_o !== 8'h00)    begin bad++; $display("FAIL fill_ninth_head got=%h want=00", bus.deq_pc_o); end
  endtask

  task automatic test_drain();
    // PC 0x08 stays presented during the first dequeue: full blocks it anyway.
    bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total += 5;
      if (bus.deq_valid_o !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, bus.deq_valid_o); end
      if (bus.deq_pc_o !== 8'(i)) begin bad++; $display("FAIL drain_pc[%0d] got=%h want=%h", i, bus.deq_pc_o, 8'(i)); end
      if (bus.deq_instr_o !== exp_instr(8'(i))) begin bad++; $display("FAIL drain_instr[%0d] got=%h want=%h", i, bus.deq_instr_o, exp_instr(8'(i))); end
      if (bus.deq_pred_taken_o !== exp_taken(8'(i))) begin bad++; $display("FAIL drain_taken[%0d] got=%b want=%b", i, bus.deq_pred_taken_o, exp_taken(8'(i))); end
      if (bus.deq_pred_target_o !== exp_target(8'(i))) begin bad++; $display("FAIL drain_target[%0d] got=%h want=%h", i, bus.deq_pred_target_o, exp_target(8'(i))); end
      $display("deq pc=%02h instr=%08h", bus.deq_pc_o, bus.deq_instr_o);
      step();
      if (i == 0) begin
        total += 2;
        if (count_o !== 4'd7) begin bad++; $display("FAIL drain_full_blocks_enq got=%0d want=7", count_o); end
        if (bus.enq_ready_o !== 1'b1) begin bad++; $display("FAIL drain_ready_after_full got=%b want=1", bus.enq_ready_o); end
        drive_enq(1'b0, 8'h00);
      end
    end
    total += 2;
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b want=0", bus.deq_valid_o); end
    if (count_o !== 4'd0)         begin bad++; $display("FAIL drain_empty_count got=%0d want=0", count_o); end
    bus.deq_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    load(8'h0A, 5);
    bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.deq_pc_o !== 8'h0A + 8'(i)) begin bad++; $display("FAIL wrap_pre_pc[%0d] got=%h want=%h", i, bus.deq_pc_o, 8'h0A + 8'(i)); end
      $display("deq pc=%02h", bus.deq_pc_o);
      step();
    end
    load(8'h10, 6);
    total++;
    if (count_o !== 4'd6) begin bad++; $display("FAIL wrap_peak_count got=%0d want=6", count_o); end
    bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total += 2;
      if (bus.deq_valid_o !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d] got=%b want=1", i, bus.deq_valid_o); end
      if (bus.deq_pc_o !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_pc[%0d] got=%h want=%h", i, bus.deq_pc_o, 8'h10 + 8'(i)); end
      $display("deq pc=%02h", bus.deq_pc_o);
      step();
    end
    total++;
    if (count_o !== 4'd0) begin bad++; $display("FAIL wrap_end_count got=%0d want=0", count_o); end
    bus.deq_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    load(8'h50, 3);
    bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_enq(1'b1, 8'h53 + 8'(i));
      total += 2;
      if (count_o !== 4'd3) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=3", i, count_o); end
      if (bus.deq_pc_o !== 8'h50 + 8'(i)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h want=%h", i, bus.deq_pc_o, 8'h50 + 8'(i)); end
      $display("enq pc=%02h deq pc=%02h", 8'h53 + 8'(i), bus.deq_pc_o);
      step();
    end
    drive_enq(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.deq_pc_o !== 8'h5A + 8'(i)) begin bad++; $display("FAIL b2b_tail_pc[%0d] got=%h want=%h", i, bus.deq_pc_o, 8'h5A + 8'(i)); end
      $display("deq pc=%02h", bus.deq_pc_o);
      step();
    end
    bus.deq_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    load(8'h60, 5);
    total++;
    if (count_o !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d want=5", count_o); end
    flush_i = 1'b1;
    bus.deq_ready_i = 1'b1;
    drive_enq(1'b1, 8'h20);
    #1;
    total += 2;
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL flush_deq_valid got=%b want=0", bus.deq_valid_o); end
    if (bus.enq_ready_o !== 1'b0) begin bad++; $display("FAIL flush_enq_ready got=%b want=0", bus.enq_ready_o); end
    step();
    flush_i = 1'b0;
    drive_enq(1'b0, 8'h00);
    #1;
    total += 3;
    if (count_o !== 4'd0)         begin bad++; $display("FAIL flush_next_count got=%0d want=0", count_o); end
    if (bus.enq_ready_o !== 1'b1) begin bad++; $display("FAIL flush_next_ready got=%b want=1", bus.enq_ready_o); end
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL flush_next_valid got=%b want=0 (pc=%h)", bus.deq_valid_o, bus.deq_pc_o); end
    step();
    total++;
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL flush_dropped_enq got=%b want=0 (pc=%h)", bus.deq_valid_o, bus.deq_pc_o); end
    bus.deq_ready_i = 1'b0;
  endtask

  task automatic test_latency();
    // Buffer empty, decode ready: entry 0x30 presented for one cycle.
    bus.deq_ready_i = 1'b1;
    drive_enq(1'b1, 8'h30);
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    total += 3;
    if (bus.deq_valid_o !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b want=1", bus.deq_valid_o); end
    if (bus.deq_pc_o !== 8'h30)   begin bad++; $display("FAIL bypass_pc got=%h want=30", bus.deq_pc_o); end
    if (count_o !== 4'd0)         begin bad++; $display("FAIL bypass_count got=%0d want=0", count_o); end
    $display("bypass pc=%02h", bus.deq_pc_o);
    step();
    drive_enq(1'b0, 8'h00);
    #1;
    total += 2;
    if (count_o !== 4'd0)         begin bad++; $display("FAIL bypass_after_count got=%0d want=0", count_o); end
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL bypass_after_valid got=%b want=0", bus.deq_valid_o); end
`else
    total++;
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL latency_same_cycle got=%b want=0", bus.deq_valid_o); end
    step();
    drive_enq(1'b0, 8'h00);
    #1;
    total += 3;
    if (bus.deq_valid_o !== 1'b1) begin bad++; $display("FAIL latency_next_valid got=%b want=1", bus.deq_valid_o); end
    if (bus.deq_pc_o !== 8'h30)   begin bad++; $display("FAIL latency_next_pc got=%h want=30", bus.deq_pc_o); end
    if (count_o !== 4'd1)         begin bad++; $display("FAIL latency_next_count got=%0d want=1", count_o); end
    $display("deq pc=%02h", bus.deq_pc_o);
    step();
    total++;
    if (count_o !== 4'd0)         begin bad++; $display("FAIL latency_drained got=%0d want=0", count_o); end
`endif
    bus.deq_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    load(8'h80, 4);
    total++;
    if (count_o !== 4'd4) begin bad++; $display("FAIL areset_pre_count got=%0d want=4", count_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (count_o !== 4'd0)         begin bad++; $display("FAIL areset_count got=%0d want=0", count_o); end
    if (bus.deq_valid_o !== 1'b0) begin bad++; $display("FAIL areset_deq_valid got=%b want=0", bus.deq_valid_o); end
    if (bus.enq_ready_o !== 1'b1) begin bad++; $display("FAIL areset_enq_ready got=%b want=1", bus.enq_ready_o); end
    if (bus.deq_pc_o !== 8'h00)   begin bad++; $display("FAIL areset_deq_pc got=%h want=00", bus.deq_pc_o); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    flush_i = 1'b0;
    bus.deq_ready_i = 1'b0;
    drive_enq(1'b0, 8'h00);
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_latency();
    test_async_reset();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
